// File: rtl/nco_fcw_sequencer.sv
// NCO phase-accumulator sequencer: serial config load, double-buffered FCW, optional linear sweep.
// Optional macro NCO_CFG_PARITY_EN adds a 25th parity beat to the serial transfer.
module nco_fcw_sequencer #(
    parameter int FCW_W   = 20,
    parameter int DWELL_W = 8,
    parameter int FRAME   = 7
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic [1:0]       Sin,
    input  logic             Sld,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Mode,
    input  logic             Vld,
    output logic             En,
    output logic [FCW_W-1:0] FCW,
    output logic             Busy,
    output logic             Err
);
    localparam int CFG_W  = 2*FCW_W + DWELL_W;
`ifdef NCO_CFG_PARITY_EN
    localparam int NBEATS = CFG_W/2 + 1;
`else
    localparam int NBEATS = CFG_W/2;
`endif
    localparam int SR_W   = 2*NBEATS;
    localparam int CNT_W  = $clog2(NBEATS + 2);
    localparam int WD_W   = $clog2(FRAME + 3);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t             r_state, w_next;
    logic [SR_W-1:0]    r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sld_q;
    logic [CFG_W-1:0]   r_shadow;
    logic               r_armed, r_from_run, r_stop_pend, r_pend, r_err;
    logic [FCW_W-1:0]   r_fcw, r_step;
    logic [DWELL_W-1:0] r_dwell, r_dcnt;
    logic [WD_W-1:0]    r_wd;

    logic               w_sld_fall, w_load_ok, w_load_bad, w_run, w_wd_trip;
    logic               w_start_acc, w_start_err;
    logic [CFG_W-1:0]   w_word;
    logic [FCW_W-1:0]   w_sh_start, w_sh_step;
    logic [DWELL_W-1:0] w_sh_dwell;

    assign w_word     = r_sr[SR_W-1 -: CFG_W];
    assign w_sh_start = r_shadow[CFG_W-1 -: FCW_W];
    assign w_sh_step  = r_shadow[DWELL_W +: FCW_W];
    assign w_sh_dwell = r_shadow[DWELL_W-1:0];
    assign w_sld_fall = r_sld_q & ~Sld;

`ifdef NCO_CFG_PARITY_EN
    assign w_load_ok  = w_sld_fall && (r_cnt == CNT_W'(NBEATS))
                      && ((^w_word[CFG_W-1:CFG_W/2]) == r_sr[1])
                      && ((^w_word[CFG_W/2-1:0]) == r_sr[0]);
`else
    assign w_load_ok  = w_sld_fall && (r_cnt == CNT_W'(NBEATS));
`endif
    assign w_load_bad = w_sld_fall & ~w_load_ok;

    // A reload issued from RUN keeps the accumulator running until LOAD exits.
    assign w_run     = (r_state == S_RUN) || ((r_state == S_LOAD) && r_from_run);
    assign w_wd_trip = w_run && !Vld && (r_wd == WD_W'(FRAME + 1));

    assign En   = w_run;
    assign Busy = (r_state != S_IDLE);
    assign FCW  = r_fcw;
    assign Err  = r_err;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_start_acc = 1'b0;
        w_start_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Sld) begin
                    w_next = S_LOAD;
                end else if (Start && !Stop) begin
                    if (r_armed) begin
                        w_next      = S_RUN;
                        w_start_acc = 1'b1;
                    end else begin
                        w_start_err = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (w_sld_fall)
                    w_next = (r_from_run && !r_stop_pend && !Stop) ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                if (Stop)     w_next = S_IDLE;
                else if (Sld) w_next = S_LOAD;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Serial capture and shadow buffer
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_sr     <= '0;
            r_cnt    <= '0;
            r_sld_q  <= 1'b0;
            r_shadow <= '0;
            r_armed  <= 1'b0;
        end else begin
            r_sld_q <= Sld;
            if (Sld) begin
                r_sr <= {r_sr[SR_W-3:0], Sin};
                if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_load_ok) begin
                r_shadow <= w_word;
                r_armed  <= 1'b1;
            end
        end
    end

    // Control flags: LOAD origin, deferred stop, pending hot reload, watchdog, error
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_from_run  <= 1'b0;
            r_stop_pend <= 1'b0;
            r_pend      <= 1'b0;
            r_wd        <= '0;
            r_err       <= 1'b0;
        end else begin
            if (r_state != S_LOAD && w_next == S_LOAD)
                r_from_run <= (r_state == S_RUN);

            if (r_state == S_LOAD && !w_sld_fall) r_stop_pend <= r_stop_pend | Stop;
            else                                  r_stop_pend <= 1'b0;

            if (w_start_acc || w_next == S_IDLE)            r_pend <= 1'b0;
            else if (w_load_ok && r_from_run && r_state == S_LOAD) r_pend <= 1'b1;
            else if (w_run && Vld)                          r_pend <= 1'b0;

            if (!w_run || Vld)                   r_wd <= '0;
            else if (r_wd != WD_W'(FRAME + 2))   r_wd <= r_wd + WD_W'(1);

            if (w_start_err || w_load_bad || w_wd_trip) r_err <= 1'b1;
            else if (w_start_acc)                       r_err <= 1'b0;
        end
    end

    // FCW datapath: only moves on Start or on a Vld edge while running
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_fcw   <= '0;
            r_step  <= '0;
            r_dwell <= '0;
            r_dcnt  <= '0;
        end else if (w_start_acc || (w_run && Vld && r_pend)) begin
            r_fcw   <= w_sh_start;
            r_step  <= w_sh_step;
            r_dwell <= w_sh_dwell;
            r_dcnt  <= '0;
        end else if (w_run && Vld && Mode && r_dwell != '0) begin
            if (r_dcnt + DWELL_W'(1) == r_dwell) begin
                r_fcw  <= r_fcw + r_step;
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + DWELL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_nco_fcw_sequencer.sv
// Directed bench for nco_fcw_sequencer: vector table of run configurations plus hand sequences.
module tb_nco_fcw_sequencer;
    localparam int FCW_W   = 20;
    localparam int DWELL_W = 8;
`ifdef NCO_CFG_PARITY_EN
    localparam int NB = 25;
`else
    localparam int NB = 24;
`endif

    logic             clk = 1'b0;
    logic             nRst = 1'b0;
    logic [1:0]       Sin = '0;
    logic             Sld = 1'b0, Start = 1'b0, Stop = 1'b0, Mode = 1'b0, Vld = 1'b0;
    logic             En, Busy, Err;
    logic [FCW_W-1:0] FCW;

    nco_fcw_sequencer #(.FCW_W(FCW_W), .DWELL_W(DWELL_W), .FRAME(7)) dut (
        .clk(clk), .nRst(nRst), .Sin(Sin), .Sld(Sld), .Start(Start), .Stop(Stop),
        .Mode(Mode), .Vld(Vld), .En(En), .FCW(FCW), .Busy(Busy), .Err(Err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    typedef struct {
        logic [19:0] st;
        logic [19:0] sp;
        logic [7:0]  dw;
        logic        md;
        int          nv;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        Sld = 0; Sin = 0; Start = 0; Stop = 0; Vld = 0; Mode = 0;
        nRst = 0;
        tick(); tick();
        nRst = 1;
        tick();
    endtask

    task automatic load_word(input logic [19:0] st, input logic [19:0] sp, input logic [7:0] dw,
                             input int nbeats, input bit vld_in);
        logic [47:0] cw;
        logic [49:0] w;
        cw = {st, sp, dw};
        w  = {cw, ^cw[47:24], ^cw[23:0]};
        for (int i = 0; i < nbeats; i++) begin
            Sld = 1;
            Sin = (i < 25) ? w[49-2*i -: 2] : 2'b00;
            Vld = vld_in && (i % 4 == 3);
            tick();
        end
        Sld = 0; Sin = 0; Vld = 0;
        tick();
    endtask

    task automatic pulse_start();
        Start = 1; tick(); Start = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{20'h10000, 20'h00000, 8'd0, 1'b0, 20, 20'h10000};
        tbl[1] = '{20'h00100, 20'h00010, 8'd3, 1'b1,  9, 20'h00130};
        tbl[2] = '{20'hFFFF0, 20'h00020, 8'd1, 1'b1,  1, 20'h00010};
        tbl[3] = '{20'h00100, 20'h00010, 8'd3, 1'b1,  8, 20'h00120};
        tbl[4] = '{20'h12345, 20'h00001, 8'd0, 1'b1,  5, 20'h12345};
        tbl[5] = '{20'h00000, 20'hFFFFF, 8'd2, 1'b1,  4, 20'hFFFFE};
        tbl[6] = '{20'h00100, 20'h00010, 8'd3, 1'b0,  9, 20'h00100};

        do_reset();
        chk("reset_En", En, 0);
        chk("reset_FCW", FCW, 0);
        chk("reset_Busy", Busy, 0);
        chk("reset_Err", Err, 0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            Mode = tbl[i].md;
            load_word(tbl[i].st, tbl[i].sp, tbl[i].dw, NB, 0);
            chk($sformatf("v%0d_idle_after_load", i), {Busy, En}, 0);
            pulse_start();
            chk($sformatf("v%0d_En", i), En, 1);
            chk($sformatf("v%0d_FCW_start", i), FCW, tbl[i].st);
            for (int k = 0; k < tbl[i].nv; k++) begin
                Vld = 1; tick(); Vld = 0; tick(); tick();
            end
            chk($sformatf("v%0d_FCW_final", i), FCW, tbl[i].exp);
            chk($sformatf("v%0d_Err", i), Err, 0);
        end

        // FCW moves only on Vld edges during a sweep
        do_reset();
        Mode = 1;
        load_word(20'h00100, 20'h00010, 8'd3, NB, 0);
        pulse_start();
        for (int k = 1; k <= 9; k++) begin
            Vld = 1; tick(); Vld = 0;
            chk($sformatf("sweep_on_vld%0d", k), FCW, 20'h00100 + 20'h00010 * (k / 3));
            tick();
            chk($sformatf("sweep_hold%0d", k), FCW, 20'h00100 + 20'h00010 * (k / 3));
        end

        // Short transfer: error, not armed, Start refused
        do_reset();
        load_word(20'h10000, 20'h0, 8'd0, NB - 1, 0);
        chk("short_Err", Err, 1);
        pulse_start();
        chk("short_start_En", En, 0);
        chk("short_start_Err", Err, 1);

        // Long transfer: error
        do_reset();
        load_word(20'h10000, 20'h0, 8'd0, NB + 1, 0);
        chk("long_Err", Err, 1);
        pulse_start();
        chk("long_start_En", En, 0);

        // Hot reload in RUN, then Start+Stop together, then restart
        do_reset();
        load_word(20'h00100, 20'h0, 8'd0, NB, 0);
        pulse_start();
        Vld = 1; tick(); Vld = 0; tick();
        load_word(20'h20000, 20'h0, 8'd0, NB, 1);
        chk("reload_En_kept", En, 1);
        chk("reload_Busy", Busy, 1);
        chk("reload_FCW_held", FCW, 20'h00100);
        tick();
        chk("reload_FCW_held2", FCW, 20'h00100);
        Vld = 1; tick(); Vld = 0;
        chk("reload_FCW_applied", FCW, 20'h20000);
        chk("reload_Err", Err, 0);
        Start = 1; Stop = 1; tick(); Start = 0; Stop = 0;
        chk("startstop_En", En, 0);
        chk("startstop_Busy", Busy, 0);
        chk("stop_FCW_held", FCW, 20'h20000);
        pulse_start();
        chk("restart_En", En, 1);
        chk("restart_FCW", FCW, 20'h20000);

        // Watchdog trips after FRAME+2 Vld-less cycles, then async reset mid-RUN
        do_reset();
        load_word(20'h00200, 20'h00010, 8'd1, NB, 0);
        Mode = 1;
        pulse_start();
        Vld = 1; tick(); Vld = 0;
        chk("wd_pre_FCW", FCW, 20'h00210);
        repeat (8) tick();
        chk("wd_8_Err", Err, 0);
        tick();
        chk("wd_9_Err", Err, 1);
        chk("wd_stay_run", En, 1);
        #2;
        nRst = 0;
        #1;
        chk("arst_En", En, 0);
        chk("arst_FCW", FCW, 0);
        chk("arst_Err", Err, 0);
        chk("arst_Busy", Busy, 0);
        @(negedge clk);
        nRst = 1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
